// File: rtl/m72_video_pkg.sv
`default_nettype none
// ============================================================================
// m72_video_pkg : shared M72 video types, palette geometry and RGB555 helpers
// Revision      : 1.0
// ============================================================================
package m72_video_pkg;

   localparam int PAL_AW = 9;

   localparam int R_LSB = 10;
   localparam int G_LSB = 5;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [3:0] pen;
      logic [3:0] col;
      logic       cp15;
      logic       cp8;
   } layer_px_t;

   typedef enum logic [1:0] {
      SRC_SPR  = 2'd0,
      SRC_A    = 2'd1,
      SRC_B    = 2'd2,
      SRC_BACK = 2'd3
   } src_t;

   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dpramv.sv
`default_nettype none
// ============================================================================
// dpramv : dual-port RAM, port A read/write, port B read-only with enable
// Revision : 1.0
// ============================================================================
module dpramv #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   input  logic          we_a,
   output logic [DW-1:0] dout_a,
   input  logic [AW-1:0] addr_b,
   input  logic          en_b,
   output logic [DW-1:0] dout_b
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Both ports return the pre-write contents on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (we_a)
         mem[addr_a] <= din_a;
      dout_a <= mem[addr_a];
   end

   always_ff @(posedge clk) begin
      if (en_b)
         dout_b <= mem[addr_b];
   end

endmodule
`default_nettype wire

// File: rtl/m72_prio_resolve.sv
`default_nettype none
// ============================================================================
// m72_prio_resolve : combinational layer priority, yields 9-bit palette index
// Revision         : 1.0
// ============================================================================
module m72_prio_resolve
   import m72_video_pkg::*;
(
   input  layer_px_t         a_px,
   input  layer_px_t         b_px,
   input  layer_px_t         s_px,
   input  logic [2:0]        layer_en,
   output logic [PAL_AW-1:0] pal_idx
);

   logic a_op, b_op, s_op, a_top, b_top;
   src_t win;

   // layer_en is {S, A, B}
   assign s_op  = layer_en[2] && (s_px.pen != 4'h0);
   assign a_op  = layer_en[1] && (a_px.pen != 4'h0);
   assign b_op  = layer_en[0] && (b_px.pen != 4'h0);
   assign a_top = a_op && (a_px.cp15 || (a_px.cp8 && a_px.pen[3]));
   assign b_top = b_op && (b_px.cp15 || (b_px.cp8 && b_px.pen[3]));

   always_comb begin
      win = SRC_BACK;
      if (a_top)
         win = SRC_A;
      else if (b_top && !a_op)
         win = SRC_B;
      else if (s_op)
         win = SRC_SPR;
      else if (a_op)
         win = SRC_A;
      else if (b_op)
         win = SRC_B;

      case (win)
         SRC_SPR: pal_idx = {1'b0, s_px.col, s_px.pen};
         SRC_A:   pal_idx = {1'b1, a_px.col, a_px.pen};
         SRC_B:   pal_idx = {1'b1, b_px.col, b_px.pen};
         default: pal_idx = {1'b1, b_px.col, 4'h0};
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/m72_layer_mixer.sv
`default_nettype none
// ============================================================================
// m72_layer_mixer : 3-stage layer priority mixer with CPU-writable palette
// Revision        : 1.0
// ============================================================================
module m72_layer_mixer #(
   parameter int PAL_AW     = 9,
   parameter int PIPE_DEPTH = 3
) (
   input  logic        CLK_32M,
   input  logic        RESET_N,
   input  logic        CE_PIX,
   input  logic [3:0]  A_BIT,
   input  logic [3:0]  B_BIT,
   input  logic [3:0]  S_BIT,
   input  logic [3:0]  A_COL,
   input  logic [3:0]  B_COL,
   input  logic [3:0]  S_COL,
   input  logic        A_CP15,
   input  logic        A_CP8,
   input  logic        B_CP15,
   input  logic        B_CP8,
   input  logic [2:0]  LAYER_EN,
   input  logic        HBLANK,
   input  logic        VBLANK,
   input  logic [15:0] DIN,
   output logic [15:0] DOUT,
   input  logic [9:0]  A,
   input  logic [1:0]  BYTE_SEL,
   input  logic        PAL_WR,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        HBLANK_O,
   output logic        VBLANK_O
);
   import m72_video_pkg::*;

   layer_px_t             a_s1, b_s1, s_s1;
   logic [2:0]            en_s1;
   logic [PAL_AW-1:0]     idx_res, idx_s2;
   logic [PIPE_DEPTH-1:0] hb_pipe, vb_pipe, vld_pipe;
   logic [7:0]            pal_lo, pal_hi, cpu_lo, cpu_hi;
   logic [15:0]           pal_word;
   logic                  show;
   logic                  unused;

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         a_s1     <= '0;
         b_s1     <= '0;
         s_s1     <= '0;
         en_s1    <= '0;
         idx_s2   <= '0;
         hb_pipe  <= '0;
         vb_pipe  <= '0;
         vld_pipe <= '0;
      end else if (CE_PIX) begin
         a_s1     <= {A_BIT, A_COL, A_CP15, A_CP8};
         b_s1     <= {B_BIT, B_COL, B_CP15, B_CP8};
         s_s1     <= {S_BIT, S_COL, 2'b00};
         en_s1    <= LAYER_EN;
         idx_s2   <= idx_res;
         hb_pipe  <= {hb_pipe[PIPE_DEPTH-2:0], HBLANK};
         vb_pipe  <= {vb_pipe[PIPE_DEPTH-2:0], VBLANK};
         // Marks stages holding real pixels; the palette data register has no reset.
         vld_pipe <= {vld_pipe[PIPE_DEPTH-2:0], 1'b1};
      end
   end

   m72_prio_resolve u_prio (
      .a_px     (a_s1),
      .b_px     (b_s1),
      .s_px     (s_s1),
      .layer_en (en_s1),
      .pal_idx  (idx_res)
   );

   dpramv #(.AW(PAL_AW), .DW(8)) u_pal_lo (
      .clk    (CLK_32M),
      .addr_a (A[PAL_AW:1]),
      .din_a  (DIN[7:0]),
      .we_a   (PAL_WR && BYTE_SEL[0]),
      .dout_a (cpu_lo),
      .addr_b (idx_s2),
      .en_b   (CE_PIX),
      .dout_b (pal_lo)
   );

   dpramv #(.AW(PAL_AW), .DW(8)) u_pal_hi (
      .clk    (CLK_32M),
      .addr_a (A[PAL_AW:1]),
      .din_a  (DIN[15:8]),
      .we_a   (PAL_WR && BYTE_SEL[1]),
      .dout_a (cpu_hi),
      .addr_b (idx_s2),
      .en_b   (CE_PIX),
      .dout_b (pal_hi)
   );

   assign pal_word = {1'b0, pal_hi[6:0], pal_lo};
   assign DOUT     = {1'b0, cpu_hi[6:0], cpu_lo};

   assign show     = vld_pipe[PIPE_DEPTH-1] && !hb_pipe[PIPE_DEPTH-1] && !vb_pipe[PIPE_DEPTH-1];
   assign R        = show ? expand5(pal_word[R_LSB +: 5]) : 8'h00;
   assign G        = show ? expand5(pal_word[G_LSB +: 5]) : 8'h00;
   assign B        = show ? expand5(pal_word[B_LSB +: 5]) : 8'h00;
   assign HBLANK_O = hb_pipe[PIPE_DEPTH-1];
   assign VBLANK_O = vb_pipe[PIPE_DEPTH-1];

   assign unused   = ^{A[0], pal_hi[7], cpu_hi[7], pal_word[15]};

endmodule
`default_nettype wire
